dmem_stage: RTL and testbench
=============================

# dmem_stage

Data-memory stage of the pipelined MIPS core: the consumer of the EX/MEM pipeline register's outputs. It decodes each load or store presented by EX/MEM and performs it against a word-addressed data array with a fixed multi-cycle access latency. While an access is in flight it raises `mem_stall` so the hazard logic freezes the pipeline, and it delivers load data to the MEM/WB register.

## Interface
- `PC_BITS`, 32, datapath and address width
- `MEM_WORDS`, 256, data array depth in 32-bit words; power of two
- `LATENCY`, 2, array access cycles per request; must be ≥1
- `clk`  in  1  clock; all state updates on rising edge
- `clr`  in  1  reset, asynchronous, active-high
- `mem_to_reg_m`  in  1  load request (EX/MEM)
- `mem_write_m`  in  1  store request (EX/MEM)
- `alu_out_m`  in  PC_BITS  byte address
- `write_data_m`  in  PC_BITS  store data
- `read_data_m`  out  PC_BITS  load result, held until the next load completes
- `mem_stall`  out  1  hold IF/ID/EX/MEM stages
- `misalign_m`  out  1  combinational flag: current request has `alu_out_m[1:0] != 0`

## Operation
- Request: `req = (mem_to_reg_m | mem_write_m) & (alu_out_m[1:0] == 0)`.
- Word index = `alu_out_m[log2(MEM_WORDS)+1 : 2]`. Upper address bits are ignored, so addresses wrap modulo `MEM_WORDS`.
- If both `mem_to_reg_m` and `mem_write_m` are set, the request is a store and `read_data_m` is not updated.
- Misaligned request:
  - `misalign_m = 1` in the same cycle.
  - No array access, no stall, no state change.
  - A store is suppressed and `read_data_m` is unchanged.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if `req`, capture op, index and `write_data_m`, set `cnt <= 1`, go to BUSY. Otherwise stay in IDLE.
  - BUSY: if `cnt == LATENCY`, perform the access and go to DONE. Otherwise `cnt <= cnt + 1`.
    - Store: `mem[idx] <= data`.
    - Load: `read_data_m <= mem[idx]`.
  - DONE: go to IDLE unconditionally.
- `mem_stall = (state == IDLE & req) | (state == BUSY)`.
- Inputs are sampled only in IDLE. Input changes during BUSY or DONE are ignored.
- The array is not reset. Only control state and `read_data_m` are reset.

## Timing
- Reset values: state = IDLE, `cnt = 0`, `read_data_m = 0`, `mem_stall = 0` (given no request), `misalign_m` follows its inputs.
- Request first visible in IDLE at cycle 0:
  - `mem_stall` is high in cycles 0 through LATENCY.
  - The access occurs at the cycle-LATENCY edge.
  - Cycle LATENCY+1 is DONE: `mem_stall = 0` and `read_data_m` is valid.
  - The pipeline advances at the end of DONE.
  - Total occupancy per access is LATENCY+2 cycles.
- Back-to-back memory instructions: the next request is seen in IDLE one cycle after DONE, so there is no overlap.
- Reset mid-operation (BUSY): return to IDLE immediately. A pending store is discarded (array unchanged) and `read_data_m` is cleared to 0.
- Load after store to the same index returns the stored value. The store completes before the load is sampled.

## Test plan
- Reset, then idle inputs -> `mem_stall = 0`, `read_data_m = 0`, state IDLE.
- Store `0xDEADBEEF` to `0x10`, LATENCY=2 -> `mem_stall` high for exactly 3 cycles, then DONE. A following load from `0x10` returns `0xDEADBEEF` after 3 stall cycles.
- Load from `0x13` (misaligned) -> `misalign_m = 1`, `mem_stall = 0`, `read_data_m` unchanged. Store to `0x22` -> array unchanged, verified by a subsequent aligned load.
- Store `0x1234` to `0x0`, then load from `0x400` (MEM_WORDS=256, wraps to index 0) -> `0x1234`.
- Assert `clr` during BUSY of a store of `0xAAAA` to `0x8` -> state IDLE. A later load from `0x8` returns the previous contents, not `0xAAAA`.
- Change `alu_out_m` and `write_data_m` mid-BUSY -> the access uses the values captured in IDLE. Assert both request bits -> treated as a store and `read_data_m` unchanged.

Source files
------------

// File: rtl/dmem_stage.sv
// ---------------------------------------------------------------------------
// dmem_stage
//
// Data-memory stage of the pipelined MIPS core. It takes the load/store
// request held in the EX/MEM register and performs it against a
// word-addressed data array with a fixed multi-cycle access latency. While an
// access is in flight, mem_stall freezes the earlier pipeline stages. Load
// data is delivered to the MEM/WB register.
//
// Parameters
//   PC_BITS    datapath and address width
//   MEM_WORDS  data array depth in 32-bit words (power of two, >= 2)
//   LATENCY    array access cycles per request (>= 1)
//
// Ports
//   clk           clock; all state updates on the rising edge
//   clr           asynchronous active-high reset
//   mem_to_reg_m  load request from EX/MEM
//   mem_write_m   store request from EX/MEM (wins if both are set)
//   alu_out_m     byte address
//   write_data_m  store data
//   read_data_m   load result, held until the next load completes
//   mem_stall     hold the IF/ID/EX/MEM stages
//   misalign_m    current request has a non-word-aligned address
// ---------------------------------------------------------------------------
module dmem_stage #(
    parameter int PC_BITS   = 32,
    parameter int MEM_WORDS = 256,
    parameter int LATENCY   = 2
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               mem_to_reg_m,
    input  logic               mem_write_m,
    input  logic [PC_BITS-1:0] alu_out_m,
    input  logic [PC_BITS-1:0] write_data_m,
    output logic [PC_BITS-1:0] read_data_m,
    output logic               mem_stall,
    output logic               misalign_m
);

    localparam int IDX_BITS = $clog2(MEM_WORDS);
    localparam int CNT_BITS = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [CNT_BITS-1:0] cnt;
    logic [CNT_BITS-1:0] cnt_next;
    logic                capture;
    logic                access;

    logic                any_op;
    logic                req;
    logic [IDX_BITS-1:0] idx_in;

    logic                is_store_q;
    logic [IDX_BITS-1:0] idx_q;
    logic [PC_BITS-1:0]  data_q;

    logic [PC_BITS-1:0]  mem [MEM_WORDS];

    // Upper address bits are deliberately dropped so addresses wrap modulo
    // the array depth; this sink only keeps them visibly consumed.
    logic unused_addr_bits;
    assign unused_addr_bits = ^alu_out_m[PC_BITS-1:IDX_BITS+2];

    // A misaligned address kills the request outright: no stall, no access.
    assign any_op     = mem_to_reg_m | mem_write_m;
    assign misalign_m = any_op & (alu_out_m[1:0] != 2'b00);
    assign req        = any_op & ~misalign_m;
    assign idx_in     = alu_out_m[IDX_BITS+1:2];

    // Stall is raised combinationally in the request cycle itself so the
    // pipeline freezes before the request can slip past in IDLE.
    assign mem_stall = ((state == IDLE) & req) | (state == BUSY);

    // State and latency counter registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic. Inputs are only looked at in IDLE; the captured copy
    // drives the access so EX/MEM changes during BUSY/DONE have no effect.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        access     = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    capture    = 1'b1;
                    cnt_next   = CNT_ONE;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt == CNT_LAST) begin
                    access     = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request capture. When both request bits are set the op is a store.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            is_store_q <= 1'b0;
            idx_q      <= '0;
            data_q     <= '0;
        end else if (capture) begin
            is_store_q <= mem_write_m;
            idx_q      <= idx_in;
            data_q     <= write_data_m;
        end
    end

    // The data array has no reset; a reset during BUSY simply never reaches
    // the access cycle, so the pending store is dropped.
    always_ff @(posedge clk) begin
        if (access && is_store_q) begin
            mem[idx_q] <= data_q;
        end
    end

    // Load result register, held between loads.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            read_data_m <= '0;
        end else if (access && !is_store_q) begin
            read_data_m <= mem[idx_q];
        end
    end

endmodule

// File: tb/tb_dmem_stage.sv
// ---------------------------------------------------------------------------
// tb_dmem_stage
//
// Self-checking bench for dmem_stage. A reference copy of the data array
// supplies expected load results, which are queued when a request is driven
// and popped when the DUT reaches its DONE cycle.
// ---------------------------------------------------------------------------
module tb_dmem_stage;

    localparam int LAT = 2;

    logic        clk;
    logic        clr;
    logic        mem_to_reg_m;
    logic        mem_write_m;
    logic [31:0] alu_out_m;
    logic [31:0] write_data_m;
    logic [31:0] read_data_m;
    logic        mem_stall;
    logic        misalign_m;

    int          compared;
    int          mismatched;
    logic [31:0] model [256];
    logic [31:0] expRead;
    logic [31:0] sbQueue [$];

    dmem_stage #(
        .PC_BITS  (32),
        .MEM_WORDS(256),
        .LATENCY  (LAT)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .mem_to_reg_m(mem_to_reg_m),
        .mem_write_m (mem_write_m),
        .alu_out_m   (alu_out_m),
        .write_data_m(write_data_m),
        .read_data_m (read_data_m),
        .mem_stall   (mem_stall),
        .misalign_m  (misalign_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive one aligned request at the start of an IDLE cycle, count stall
    // cycles until DONE, then compare the load result with the scoreboard.
    // With corrupt set, address and data are changed while the access is busy.
    task automatic applyStimulus(input string tag, input logic ld, input logic st,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic corrupt);
        int   stallCycles;
        logic done;
        logic [7:0] idx;
        stallCycles = 0;
        done        = 1'b0;
        idx         = addr[9:2];
        @(posedge clk);
        #1;
        mem_to_reg_m = ld;
        mem_write_m  = st;
        alu_out_m    = addr;
        write_data_m = data;
        if (st) model[idx] = data;
        else if (ld) expRead = model[idx];
        sbQueue.push_back(expRead);
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (i == 0) checkOutput({tag, " misalign"}, {31'b0, misalign_m}, 32'd0);
            if (mem_stall) begin
                stallCycles++;
                if (corrupt && stallCycles == 2) begin
                    alu_out_m    = addr ^ 32'h4;
                    write_data_m = ~data;
                end
            end else begin
                done = 1'b1;
            end
        end
        if (!done) checkOutput({tag, " timeout"}, {31'b0, done}, 32'd1);
        checkOutput({tag, " stall"}, 32'(stallCycles), 32'(LAT + 1));
        checkOutput({tag, " rdata"}, read_data_m, sbQueue.pop_front());
    endtask

    task automatic applyMisaligned(input string tag, input logic ld, input logic st,
                                   input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk);
        #1;
        mem_to_reg_m = ld;
        mem_write_m  = st;
        alu_out_m    = addr;
        write_data_m = data;
        @(negedge clk);
        checkOutput({tag, " misalign"}, {31'b0, misalign_m}, 32'd1);
        checkOutput({tag, " stall"}, {31'b0, mem_stall}, 32'd0);
        @(negedge clk);
        checkOutput({tag, " stall2"}, {31'b0, mem_stall}, 32'd0);
        checkOutput({tag, " rdata"}, read_data_m, expRead);
        applyIdle();
    endtask

    task automatic applyIdle();
        @(posedge clk);
        #1;
        mem_to_reg_m = 1'b0;
        mem_write_m  = 1'b0;
        alu_out_m    = 32'h0;
        write_data_m = 32'h0;
    endtask

    // Start a store, then reset while it is in BUSY; the model is untouched.
    task automatic applyResetDuringStore(input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk);
        #1;
        mem_to_reg_m = 1'b0;
        mem_write_m  = 1'b1;
        alu_out_m    = addr;
        write_data_m = data;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst busy stall", {31'b0, mem_stall}, 32'd1);
        clr         = 1'b1;
        mem_write_m = 1'b0;
        #1;
        checkOutput("rst stall", {31'b0, mem_stall}, 32'd0);
        checkOutput("rst rdata", read_data_m, 32'd0);
        expRead = 32'd0;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compared     = 0;
        mismatched   = 0;
        expRead      = 32'd0;
        clr          = 1'b1;
        mem_to_reg_m = 1'b0;
        mem_write_m  = 1'b0;
        alu_out_m    = 32'h0;
        write_data_m = 32'h0;
        repeat (3) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        checkOutput("reset stall", {31'b0, mem_stall}, 32'd0);
        checkOutput("reset rdata", read_data_m, 32'd0);

        applyStimulus("st 10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        applyStimulus("ld 10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        applyStimulus("st 20", 1'b0, 1'b1, 32'h20, 32'h0BAD0BAD, 1'b0);
        applyIdle();

        applyMisaligned("mis ld 13", 1'b1, 1'b0, 32'h13, 32'h0);
        applyMisaligned("mis st 22", 1'b0, 1'b1, 32'h22, 32'hFFFF0000);
        applyStimulus("ld 20", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

        applyStimulus("st 0", 1'b0, 1'b1, 32'h0, 32'h1234, 1'b0);
        applyStimulus("ld 400", 1'b1, 1'b0, 32'h400, 32'h0, 1'b0);

        applyStimulus("st 8", 1'b0, 1'b1, 32'h8, 32'h5555, 1'b0);
        applyIdle();
        applyResetDuringStore(32'h8, 32'hAAAA);
        applyStimulus("ld 8", 1'b1, 1'b0, 32'h8, 32'h0, 1'b0);

        applyStimulus("st 34", 1'b0, 1'b1, 32'h34, 32'h3434, 1'b0);
        applyStimulus("st 30 chg", 1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 1'b1);
        applyStimulus("ld 30", 1'b1, 1'b0, 32'h30, 32'h0, 1'b0);
        applyStimulus("ld 34", 1'b1, 1'b0, 32'h34, 32'h0, 1'b0);

        applyStimulus("ld 10 again", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        applyStimulus("both 40", 1'b1, 1'b1, 32'h40, 32'h77, 1'b0);
        applyStimulus("ld 40", 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
        applyIdle();
        @(negedge clk);
        checkOutput("final stall", {31'b0, mem_stall}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
